id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// ID/EX pipeline register with operand forwarding and load-use hazard detection; sits directly upstream of the EX-stage ALU.
// Drives the ALU a/b/op inputs and carries rd, control and store data onward to EX/MEM.
// PARAMETERS
// XLEN  32  datapath width; the core is RV32IM, so only 32 is supported.
// PORTS
// clk               in   1     core clock, rising edge
// rst_n             in   1     reset: one clock; reset is synchronous and active-low
// stall_i           in   1     global stall (e.g. memory wait): hold all stage registers
// flush_i           in   1     branch/exception flush: load a bubble
// id_valid_i        in   1     ID holds a valid instruction
// id_pc_i           in   32    PC of the ID instruction
// id_rs1_data_i     in   32    register-file rs1 read data
// id_rs2_data_i     in   32    register-file rs2 read data
// id_imm_i          in   32    sign-extended immediate
// id_rs1_addr_i     in   5     rs1 index
// id_rs2_addr_i     in   5     rs2 index
// id_rd_addr_i      in   5     rd index
// id_alu_op_i       in   enum  rv32_pkg::alu_op_e
// id_src_sel_i      in   2     [0]: a=PC(1)/rs1(0); [1]: b=imm(1)/rs2(0)
// id_ctrl_i         in   3     {reg_we, mem_re, mem_we}
// exm_rd_addr_i     in   5     EX/MEM destination register
// exm_we_i          in   1     EX/MEM writes a register
// exm_data_i        in   32    EX/MEM result
// mwb_rd_addr_i     in   5     MEM/WB destination register
// mwb_we_i          in   1     MEM/WB writes a register
// mwb_data_i        in   32    MEM/WB write-back data
// ex_valid_o        out  1     EX holds a valid instruction
// ex_pc_o           out  32    registered PC
// ex_alu_a_o        out  32    ALU operand a (forwarded)
// ex_alu_b_o        out  32    ALU operand b (forwarded or immediate)
// ex_alu_op_o       out  enum  ALU opcode
// ex_store_data_o   out  32    forwarded rs2 value, used as store data
// ex_rd_addr_o      out  5     registered rd
// ex_ctrl_o         out  3     registered {reg_we, mem_re, mem_we}; forced to 0 when not valid
// load_use_stall_o  out  1     hazard request: the upstream stages must hold IF/ID
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - All registers clear: valid=0, pc/rs/imm/rd=0, ctrl=0, op=ALU_ADD.
//   - Outputs therefore read 0 (ALU_ADD on ex_alu_op_o) from the first cycle after reset.
// - Per-edge update priority: reset > flush_i > stall_i > load-use bubble > normal load.
//   - flush_i loads a bubble (valid=0, ctrl=0) even when stall_i is high.
//   - stall_i alone holds every register unchanged.
//   - A load-use bubble loads valid=0, ctrl=0 while IF/ID holds; the stalled instruction loads on the next free edge.
//   - Normal load captures all id_* inputs. When id_valid_i=0, ctrl is forced to 0.
// - Load-use hazard: load_use_stall_o = ex_valid & ex_mem_re & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
//   - Combinational; the request is independent of stall_i.
//   - Exactly one bubble per hazard. After the bubble, the loaded data arrives through the MEM/WB forwarding path.
// - Forwarding: combinational, applied to the registered rs1/rs2 values; one 3:1 mux per source.
//   - EX/MEM has priority over MEM/WB (youngest producer wins).
//   - A path is taken only if its we=1, its rd != 0 and rd equals the registered rs index; x0 is never forwarded.
// - Operand select: ex_alu_a_o = src_a_sel ? pc : fwd_rs1; ex_alu_b_o = src_b_sel ? imm : fwd_rs2.
//   - ex_store_data_o is always fwd_rs2, independent of src_b_sel.
// - Latency: 1 cycle from an ID capture to the EX outputs. Forwarded operands are same-cycle combinational.
// - Bubbles are architecturally inert: ctrl=0, so no register write and no memory access downstream.
// TESTING
// - Reset, then release: all outputs 0, ex_alu_op_o=ALU_ADD, load_use_stall_o=0.
// - Back-to-back dependence:
//   - Setup: ID addi x5 loads; next cycle exm_rd=5, exm_we=1, exm_data=0x10; registered rs1=5.
//   - Required: ex_alu_a_o=0x10.
//   - Also drive mwb_rd=5, mwb_data=0x20 at the same time: ex_alu_a_o stays 0x10 (EX/MEM priority).
// - x0 is not forwarded: exm_rd=0, exm_we=1, exm_data=0xDEAD, rs1=0, reg data 0 -> ex_alu_a_o=0.
// - Load-use:
//   - Setup: EX holds lw x7 (mem_re=1); ID has add x8,x7,x1.
//   - Required: load_use_stall_o=1; next cycle ex_valid_o=0, ex_ctrl_o=0.
//   - Following cycle: the add is in EX and takes mwb_data (x7) as operand a.
// - Flush vs stall: flush_i=1 and stall_i=1 on the same edge -> ex_valid_o=0, ex_ctrl_o=0.
//   - Required: with stall_i=1 alone for 3 cycles, all outputs stay constant.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use hazard detection
package rv32_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM, ALU_PASS
    } alu_op_e;
endpackage

module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic [4:0]      id_rd_addr_i,
    input  alu_op_e         id_alu_op_i,
    input  logic [1:0]      id_src_sel_i,
    input  logic [2:0]      id_ctrl_i,
    input  logic [4:0]      exm_rd_addr_i,
    input  logic            exm_we_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic [4:0]      mwb_rd_addr_i,
    input  logic            mwb_we_i,
    input  logic [XLEN-1:0] mwb_data_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_alu_a_o,
    output logic [XLEN-1:0] ex_alu_b_o,
    output alu_op_e         ex_alu_op_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic [2:0]      ex_ctrl_o,
    output logic            load_use_stall_o
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
    alu_op_e         op_q, op_d;
    logic [1:0]      src_sel_q, src_sel_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            bubble, load;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // A load in EX whose rd feeds the instruction in ID needs one bubble before the data can be forwarded
    always_comb begin
        load_use_stall_o = valid_q & ctrl_q[1] & (rd_q != 5'd0) &
                           ((rd_q == id_rs1_addr_i) | (rd_q == id_rs2_addr_i));
        bubble           = flush_i | (!stall_i & load_use_stall_o);
        load             = !flush_i & !stall_i & !load_use_stall_o;
    end

    // Next state: flush and hazard insert a bubble, stall holds, otherwise capture ID
    always_comb begin
        valid_d    = bubble ? 1'b0 : load ? id_valid_i : valid_q;
        ctrl_d     = bubble ? 3'b0 : load ? (id_valid_i ? id_ctrl_i : 3'b0) : ctrl_q;
        pc_d       = load ? id_pc_i       : pc_q;
        rs1_d      = load ? id_rs1_data_i : rs1_q;
        rs2_d      = load ? id_rs2_data_i : rs2_q;
        imm_d      = load ? id_imm_i      : imm_q;
        rs1_addr_d = load ? id_rs1_addr_i : rs1_addr_q;
        rs2_addr_d = load ? id_rs2_addr_i : rs2_addr_q;
        rd_d       = load ? id_rd_addr_i  : rd_q;
        op_d       = load ? id_alu_op_i   : op_q;
        src_sel_d  = load ? id_src_sel_i  : src_sel_q;
    end

    // Stage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            op_q       <= ALU_ADD;
            src_sel_q  <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            src_sel_q  <= src_sel_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Forwarding (youngest producer first, x0 never forwarded) and operand select
    always_comb begin
        fwd_rs1         = (exm_we_i && exm_rd_addr_i != 5'd0 && exm_rd_addr_i == rs1_addr_q) ? exm_data_i :
                          (mwb_we_i && mwb_rd_addr_i != 5'd0 && mwb_rd_addr_i == rs1_addr_q) ? mwb_data_i : rs1_q;
        fwd_rs2         = (exm_we_i && exm_rd_addr_i != 5'd0 && exm_rd_addr_i == rs2_addr_q) ? exm_data_i :
                          (mwb_we_i && mwb_rd_addr_i != 5'd0 && mwb_rd_addr_i == rs2_addr_q) ? mwb_data_i : rs2_q;
        ex_valid_o      = valid_q;
        ex_pc_o         = pc_q;
        ex_alu_a_o      = src_sel_q[0] ? pc_q : fwd_rs1;
        ex_alu_b_o      = src_sel_q[1] ? imm_q : fwd_rs2;
        ex_alu_op_o     = op_q;
        ex_store_data_o = fwd_rs2;
        ex_rd_addr_o    = rd_q;
        ex_ctrl_o       = valid_q ? ctrl_q : 3'b0;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic against a behavioural ID/EX model
module tb_id_ex_stage;
    import rv32_pkg::*;

    logic clk = 1'b0, rst_n, stall, flush, id_valid, exm_we, mwb_we;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exm_data, mwb_data;
    logic [4:0] id_rs1, id_rs2, id_rd, exm_rd, mwb_rd;
    alu_op_e id_op, ex_op;
    logic [1:0] id_sel;
    logic [2:0] id_ctrl;
    logic ex_valid, load_use;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store;
    logic [4:0] ex_rd;
    logic [2:0] ex_ctrl;
    int n_cmp = 0, n_err = 0;

    // Architectural contents of the EX slot as the pipeline rules define it
    typedef struct packed {
        logic v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0] a1, a2, rd;
        alu_op_e op;
        logic [1:0] sel;
        logic [2:0] ctrl;
    } ex_t;
    ex_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2), .id_rd_addr_i(id_rd), .id_alu_op_i(id_op),
        .id_src_sel_i(id_sel), .id_ctrl_i(id_ctrl), .exm_rd_addr_i(exm_rd), .exm_we_i(exm_we),
        .exm_data_i(exm_data), .mwb_rd_addr_i(mwb_rd), .mwb_we_i(mwb_we), .mwb_data_i(mwb_data),
        .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_alu_a_o(ex_a), .ex_alu_b_o(ex_b),
        .ex_alu_op_o(ex_op), .ex_store_data_o(ex_store), .ex_rd_addr_o(ex_rd), .ex_ctrl_o(ex_ctrl),
        .load_use_stall_o(load_use)
    );

    // Value a register source sees: newest in-flight writer of that register, else the file value
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (exm_we && exm_rd != 0 && exm_rd == a) return exm_data;
        if (mwb_we && mwb_rd != 0 && mwb_rd == a) return mwb_data;
        return v;
    endfunction

    function automatic logic hazard();
        return m.v && m.ctrl[1] && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_op = ALU_ADD; id_sel = 0; id_ctrl = 0;
        exm_rd = 0; exm_we = 0; exm_data = 0; mwb_rd = 0; mwb_we = 0; mwb_data = 0;
    endtask

    task automatic set_id(input logic [31:0] pc, r1d, r2d, imm, input logic [4:0] a1, a2, rd,
                          input alu_op_e op, input logic [1:0] sel, input logic [2:0] ctrl);
        id_valid = 1; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
        id_rs1 = a1; id_rs2 = a2; id_rd = rd; id_op = op; id_sel = sel; id_ctrl = ctrl;
    endtask

    // Advance one clock, applying the same edge to the reference model
    task automatic step();
        ex_t n = m;
        if (!rst_n) n = '0;
        else if (flush) begin n.v = 0; n.ctrl = 0; end
        else if (stall) n = m;
        else if (hazard()) begin n.v = 0; n.ctrl = 0; end
        else n = '{v: id_valid, pc: id_pc, r1: id_rs1_data, r2: id_rs2_data, imm: id_imm, a1: id_rs1,
                   a2: id_rs2, rd: id_rd, op: id_op, sel: id_sel, ctrl: id_valid ? id_ctrl : 3'b0};
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        set_id(32'h1234, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, ALU_SUB, 2'b11, 3'b111);
        step(); step();
        idle(); rst_n = 1; #1;
        n_cmp++;
        if ({ex_valid, ex_pc, ex_a, ex_b, ex_store, ex_rd, ex_ctrl, load_use} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b pc=%h a=%h b=%h st=%h rd=%0d ctrl=%b lu=%b, want all 0",
                              ex_valid, ex_pc, ex_a, ex_b, ex_store, ex_rd, ex_ctrl, load_use);
        end
        n_cmp++;
        if (ex_op !== ALU_ADD) begin n_err++; $display("FAIL reset_op: got %0d want %0d", ex_op, ALU_ADD); end
    endtask

    task automatic test_back_to_back();
        idle();
        set_id(32'h40, 32'h3, 32'h0, 32'h4, 5'd5, 5'd0, 5'd5, ALU_ADD, 2'b10, 3'b100);
        step();
        idle(); exm_rd = 5; exm_we = 1; exm_data = 32'h10; #1;
        n_cmp++;
        if (ex_a !== 32'h10) begin n_err++; $display("FAIL b2b_exm: got %h want 00000010", ex_a); end
        n_cmp++;
        if ({ex_valid, ex_ctrl, ex_b} !== {1'b1, 3'b100, 32'h4}) begin
            n_err++; $display("FAIL b2b_ctrl_imm: got v=%b ctrl=%b b=%h want v=1 ctrl=100 b=00000004", ex_valid, ex_ctrl, ex_b);
        end
        mwb_rd = 5; mwb_we = 1; mwb_data = 32'h20; #1;
        n_cmp++;
        if (ex_a !== 32'h10) begin n_err++; $display("FAIL b2b_priority: got %h want 00000010", ex_a); end
        exm_we = 0; #1;
        n_cmp++;
        if (ex_a !== 32'h20) begin n_err++; $display("FAIL b2b_mwb: got %h want 00000020", ex_a); end
    endtask

    task automatic test_x0();
        idle();
        set_id(32'h80, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, ALU_ADD, 2'b00, 3'b100);
        step();
        idle(); exm_rd = 0; exm_we = 1; exm_data = 32'hDEAD; mwb_rd = 0; mwb_we = 1; mwb_data = 32'hBEEF; #1;
        n_cmp++;
        if ({ex_a, ex_b, ex_store} !== '0) begin
            n_err++; $display("FAIL x0_no_fwd: got a=%h b=%h st=%h want 0", ex_a, ex_b, ex_store);
        end
    endtask

    task automatic test_load_use();
        idle();
        set_id(32'h100, 32'h200, 32'h0, 32'h8, 5'd1, 5'd0, 5'd7, ALU_ADD, 2'b10, 3'b110);
        step();
        set_id(32'h104, 32'h0, 32'h5, 32'h0, 5'd7, 5'd1, 5'd8, ALU_ADD, 2'b00, 3'b100); #1;
        n_cmp++;
        if (load_use !== 1'b1) begin n_err++; $display("FAIL lu_request: got %b want 1", load_use); end
        step();
        n_cmp++;
        if ({ex_valid, ex_ctrl, load_use} !== 5'b0) begin
            n_err++; $display("FAIL lu_bubble: got v=%b ctrl=%b lu=%b want 0 000 0", ex_valid, ex_ctrl, load_use);
        end
        step();
        idle(); mwb_rd = 7; mwb_we = 1; mwb_data = 32'h77; #1;
        n_cmp++;
        if ({ex_valid, ex_ctrl, ex_rd, ex_a, ex_b} !== {1'b1, 3'b100, 5'd8, 32'h77, 32'h5}) begin
            n_err++; $display("FAIL lu_resume: got v=%b ctrl=%b rd=%0d a=%h b=%h want 1 100 8 00000077 00000005",
                              ex_valid, ex_ctrl, ex_rd, ex_a, ex_b);
        end
    endtask

    task automatic test_flush_stall();
        idle();
        set_id(32'h100, 32'hAAAA, 32'hBBBB, 32'hCC, 5'd9, 5'd10, 5'd11, ALU_XOR, 2'b01, 3'b101);
        step();
        for (int i = 0; i < 3; i++) begin
            stall = 1; id_valid = 1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_ctrl = 3'($urandom); id_op = ALU_SUB;
            step();
            n_cmp++;
            if ({ex_valid, ex_pc, ex_a, ex_b, ex_store, ex_rd, ex_ctrl, load_use} !==
                {1'b1, 32'h100, 32'h100, 32'hBBBB, 32'hBBBB, 5'd11, 3'b101, 1'b0} || ex_op !== ALU_XOR) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h a=%h b=%h st=%h rd=%0d ctrl=%b op=%0d lu=%b",
                                  i, ex_valid, ex_pc, ex_a, ex_b, ex_store, ex_rd, ex_ctrl, ex_op, load_use);
            end
        end
        flush = 1; stall = 1;
        step();
        n_cmp++;
        if ({ex_valid, ex_ctrl} !== 4'b0) begin
            n_err++; $display("FAIL flush_over_stall: got v=%b ctrl=%b want 0 000", ex_valid, ex_ctrl);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 99) < 15); flush = ($urandom_range(0, 99) < 8);
            id_valid = ($urandom_range(0, 99) < 85); id_pc = $urandom; id_rs1_data = $urandom;
            id_rs2_data = $urandom; id_imm = $urandom; id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
            id_op = alu_op_e'($urandom_range(0, 15)); id_sel = 2'($urandom); id_ctrl = 3'($urandom);
            exm_rd = 5'($urandom_range(0, 3)); exm_we = 1'($urandom); exm_data = $urandom;
            mwb_rd = 5'($urandom_range(0, 3)); mwb_we = 1'($urandom); mwb_data = $urandom;
            #1;
            n_cmp++;
            if (load_use !== hazard()) begin n_err++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, load_use, hazard()); end
            n_cmp++;
            if ({ex_valid, ex_ctrl} !== {m.v, m.v ? m.ctrl : 3'b0}) begin
                n_err++; $display("FAIL rnd_valid_ctrl[%0d]: got %b %b want %b %b", i, ex_valid, ex_ctrl, m.v, m.ctrl);
            end
            if (m.v) begin
                n_cmp++;
                if ({ex_pc, ex_rd} !== {m.pc, m.rd} || ex_op !== m.op) begin
                    n_err++; $display("FAIL rnd_fields[%0d]: got pc=%h rd=%0d op=%0d want pc=%h rd=%0d op=%0d",
                                      i, ex_pc, ex_rd, ex_op, m.pc, m.rd, m.op);
                end
                n_cmp++;
                if ({ex_a, ex_b, ex_store} !== {m.sel[0] ? m.pc : fwd(m.a1, m.r1), m.sel[1] ? m.imm : fwd(m.a2, m.r2),
                                                fwd(m.a2, m.r2)}) begin
                    n_err++; $display("FAIL rnd_operands[%0d]: got a=%h b=%h st=%h want a=%h b=%h st=%h", i, ex_a, ex_b, ex_store,
                                      m.sel[0] ? m.pc : fwd(m.a1, m.r1), m.sel[1] ? m.imm : fwd(m.a2, m.r2), fwd(m.a2, m.r2));
                end
            end
            step();
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_back_to_back();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
